// File: rtl/debug_pkg.sv
// Shared constants, state encoding and frame sizing for the debug counter readout.
package debug_pkg;

    localparam int unsigned NUM_CNT_DEF  = 5;
    localparam int unsigned CNT_W_DEF    = 64;
    localparam int unsigned OUT_W_DEF    = 32;
    localparam int unsigned PERIOD_W_DEF = 32;
    localparam int unsigned FRAME_ID_W   = 16;

    localparam logic [15:0] HDR_MAGIC = 16'hDB60;

    localparam int unsigned WORDS_PER_CNT = CNT_W_DEF / OUT_W_DEF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_HDR  = ST_HDR,
        S_DATA = ST_DATA
    } state_e;

    // Payload words per frame (the header word is not included).
    function automatic int unsigned frame_data_words(input int unsigned num_cnt,
                                                     input int unsigned cnt_w,
                                                     input int unsigned out_w);
        return num_cnt * (cnt_w / out_w);
    endfunction

endpackage

// File: rtl/debug_period_timer.sv
// Free-running auto-trigger timer: pulses auto_tick_o once every auto_period_i cycles.
module debug_period_timer
    import debug_pkg::*;
#(
    parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                auto_en_i,
    input  logic [PERIOD_W-1:0] auto_period_i,
    output logic                auto_tick_o
);

    logic [PERIOD_W-1:0] timer_q;
    logic [PERIOD_W-1:0] timer_d;
    logic                run_c;

    // Period 0 or disabled holds the timer at 0 so re-enabling starts a full period.
    always_comb begin
        run_c       = auto_en_i && (auto_period_i != '0);
        auto_tick_o = run_c && (timer_q == auto_period_i - PERIOD_W'(1));
        timer_d     = '0;
        if (run_c && !auto_tick_o) begin
            timer_d = timer_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/debug_counter_readout.sv
// Snapshots the debug counters on a trigger and streams them as a framed
// sequence of words (header, then counter 0..N-1, low word first).
module debug_counter_readout
    import debug_pkg::*;
#(
    parameter int unsigned NUM_CNT  = NUM_CNT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF,
    parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_flat,
    input  logic                     snap_req,
    input  logic                     auto_en,
    input  logic [PERIOD_W-1:0]      auto_period,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic [FRAME_ID_W-1:0]    frame_id,
    output logic [FRAME_ID_W-1:0]    overrun_count
);

    localparam int unsigned NUM_WORDS = frame_data_words(NUM_CNT, CNT_W, OUT_W);
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e                     state_q;
    logic [NUM_CNT*CNT_W-1:0]   snapshot_q;
    logic [IDX_W-1:0]           word_idx_q;
    logic [OUT_W-1:0]           out_data_q;
    logic                       out_valid_q;
    logic                       out_last_q;
    logic [FRAME_ID_W-1:0]      frame_id_q;
    logic [FRAME_ID_W-1:0]      overrun_q;

    logic                       auto_tick_c;
    logic                       trig_c;
    logic [IDX_W-1:0]           nxt_idx_c;
    logic [OUT_W-1:0]           snap_words_c [NUM_WORDS];

    debug_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .auto_en_i     (auto_en),
        .auto_period_i (auto_period),
        .auto_tick_o   (auto_tick_c)
    );

    // Word view of the snapshot: word k sits at bits [k*OUT_W +: OUT_W].
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_words
        assign snap_words_c[k] = snapshot_q[k*OUT_W +: OUT_W];
    end

    assign trig_c    = snap_req | auto_tick_c;
    assign nxt_idx_c = (state_q == S_DATA) ? word_idx_q + IDX_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            snapshot_q  <= '0;
            word_idx_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_id_q  <= '0;
            overrun_q   <= '0;
        end else begin
            // Any trigger outside IDLE is dropped, including one on the final handshake.
            if (trig_c && (state_q != S_IDLE) && (overrun_q != '1)) begin
                overrun_q <= overrun_q + FRAME_ID_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (trig_c) begin
                        snapshot_q  <= cnt_flat;
                        state_q     <= S_HDR;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        out_data_q  <= OUT_W'({HDR_MAGIC, frame_id_q});
                    end
                end
                S_HDR, S_DATA: begin
                    if (out_ready) begin
                        if ((state_q == S_DATA) && out_last_q) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            frame_id_q  <= frame_id_q + FRAME_ID_W'(1);
                        end else begin
                            state_q    <= S_DATA;
                            word_idx_q <= nxt_idx_c;
                            out_data_q <= snap_words_c[nxt_idx_c];
                            out_last_q <= (nxt_idx_c == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_id      = frame_id_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_debug_counter_readout.sv
// Scoreboard bench for debug_counter_readout: a cycle-level reference model queues
// expected words, a monitor pops and compares them on every output handshake.
`timescale 1ns/1ps
module tb_debug_counter_readout;
    import debug_pkg::*;

    localparam int unsigned NC = 5;
    localparam int unsigned CW = 64;
    localparam int unsigned OW = 32;
    localparam int unsigned PW = 32;
    localparam int unsigned NW = NC * CW / OW;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC*CW-1:0] cnt_flat;
    logic            snap_req;
    logic            auto_en;
    logic [PW-1:0]   auto_period;
    logic [OW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic [15:0]     frame_id;
    logic [15:0]     overrun_count;

    debug_counter_readout dut (
        .clk           (clk),
        .rst           (rst),
        .cnt_flat      (cnt_flat),
        .snap_req      (snap_req),
        .auto_en       (auto_en),
        .auto_period   (auto_period),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .frame_id      (frame_id),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    int   vectors    = 0;
    int   miscompares = 0;
    int   hs_cnt     = 0;
    logic chk_en     = 1'b0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level view of triggers, handshakes and counters.
    logic            m_busy = 1'b0;
    int              m_rem  = 0;
    logic [15:0]     m_fid  = '0;
    logic [15:0]     m_ovr  = '0;
    longint unsigned m_en   = 0;

    always @(posedge clk) begin
        logic tick_m;
        logic was_busy;
        logic [CW-1:0] v;
        if (rst) begin
            m_busy = 1'b0;
            m_rem  = 0;
            m_fid  = '0;
            m_ovr  = '0;
            m_en   = 0;
            exp_q.delete();
        end else begin
            tick_m = 1'b0;
            if (auto_en && auto_period != 0) begin
                m_en++;
                tick_m = (m_en % longint'(auto_period)) == 0;
            end else begin
                m_en = 0;
            end
            was_busy = m_busy;
            if (was_busy && out_ready) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_fid++;
                end
            end
            if (snap_req || tick_m) begin
                if (!was_busy) begin
                    exp_q.push_back('{data: {16'hDB60, m_fid}, last: 1'b0});
                    for (int c = 0; c < int'(NC); c++) begin
                        v = cnt_flat[c*CW +: CW];
                        for (int w = 0; w < int'(WORDS_PER_CNT); w++) begin
                            exp_q.push_back('{data: v[w*OW +: OW],
                                              last: (c == int'(NC) - 1) && (w == int'(WORDS_PER_CNT) - 1)});
                        end
                    end
                    m_busy = 1'b1;
                    m_rem  = int'(NW) + 1;
                end else if (m_ovr != 16'hFFFF) begin
                    m_ovr++;
                end
            end
        end
    end

    // Monitor: status every cycle, stream words on each handshake.
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("out_valid", 64'(out_valid), 64'(m_busy));
            check("frame_id", 64'(frame_id), 64'(m_fid));
            check("overrun_count", 64'(overrun_count), 64'(m_ovr));
            if (prev_stall && out_valid) begin
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_last", 64'(out_last), 64'(prev_last));
            end
            prev_stall = out_valid && !out_ready && !rst;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready && !rst) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %0h, expected no word at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 64'(out_data), 64'(e.data));
                    check("last", 64'(out_last), 64'(e.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cnt();
        for (int i = 0; i < int'(NW); i++) cnt_flat[i*OW +: OW] = $urandom();
    endtask

    int unsigned periods [5] = '{0, 7, 13, 25, 40};

    initial begin
        int n;
        int start;
        int bcnt;
        rst = 1'b1; snap_req = 1'b0; auto_en = 1'b0; auto_period = '0;
        out_ready = 1'b1; cnt_flat = '0;
        tick(); tick();
        chk_en = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_frame_id", 64'(frame_id), 64'(0));
        check("rst_overrun", 64'(overrun_count), 64'(0));
        rst = 1'b0;
        tick();

        // Directed frame with known counter values, full throughput.
        cnt_flat = {64'h0, 64'h5, 64'h4, 64'h3, 64'h2_0000_0001};
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        bcnt = busy ? 1 : 0;
        repeat (15) begin tick(); if (busy) bcnt++; end
        check("t1_busy_cycles", 64'(bcnt), 64'(11));
        check("t1_frame_id", 64'(frame_id), 64'(1));

        // Backpressure with counters changing every cycle.
        rand_cnt();
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        bcnt = busy ? 1 : 0;
        for (int k = 0; k < 30; k++) begin
            out_ready = (k % 2 == 0);
            rand_cnt();
            tick();
            if (busy) bcnt++;
        end
        out_ready = 1'b1;
        check("t2_busy_cycles", 64'(bcnt), 64'(21));
        tick();

        // Overrun: three drops mid-frame, one on the final handshake.
        rand_cnt();
        for (int e = 0; e < 14; e++) begin
            snap_req = (e == 0 || e == 3 || e == 5 || e == 7 || e == 11);
            tick();
        end
        snap_req = 1'b0;
        check("t3_overrun", 64'(overrun_count), 64'(4));
        check("t3_frame_id", 64'(frame_id), 64'(3));

        // Auto trigger every 20 cycles, then period 0 disables it.
        auto_en = 1'b1; auto_period = 32'd20;
        repeat (95) begin rand_cnt(); tick(); end
        check("t4_frame_id", 64'(frame_id), 64'(7));
        auto_period = '0;
        repeat (60) begin rand_cnt(); tick(); end
        check("t4_no_frames", 64'(frame_id), 64'(7));
        auto_en = 1'b0;

        // Reset in the middle of a frame.
        rand_cnt();
        start = hs_cnt;
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        n = 0;
        while ((hs_cnt - start) < 6 && n < 40) begin tick(); n++; end
        check("t5_reached_word5", 64'((hs_cnt - start) >= 6), 64'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_out_valid", 64'(out_valid), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_frame_id", 64'(frame_id), 64'(0));
        rand_cnt();
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        check("t5_header", 64'(out_data), 64'(32'hDB60_0000));
        repeat (14) tick();
        check("t5_frame_done", 64'(frame_id), 64'(1));

        // Randomised traffic: triggers, backpressure, auto periods.
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                auto_en = 1'b0;
                tick();
                auto_period = periods[$urandom_range(0, 4)];
                auto_en = ($urandom % 2) == 1;
            end
            rand_cnt();
            snap_req  = ($urandom % 10) == 0;
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        auto_en = 1'b0; snap_req = 1'b0; out_ready = 1'b1;
        repeat (30) tick();

        // Saturation of the overrun counter under a permanently stalled frame.
        out_ready = 1'b0; snap_req = 1'b1;
        repeat (65540) tick();
        snap_req = 1'b0; out_ready = 1'b1;
        repeat (20) tick();
        check("t6_overrun_sat", 64'(overrun_count), 64'(16'hFFFF));
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
